// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and helpers for the load/store unit.
// Build option: LSU_MISALIGN_TRAP_EN turns misaligned accesses into errors.
package lsu_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_FLW   = 7'b0000111;
    localparam logic [6:0] OP_FSW   = 7'b0100111;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } lsu_state_e;

    // size: funct3[1:0] (00 byte, 01 half, 10 word)
    function automatic logic [3:0] strobe_pattern(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] base;
        unique case (size)
            2'b00:   base = 4'b0001;
            2'b01:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << off;
    endfunction

    function automatic logic f3_legal(
        input logic       is_store,
        input logic       is_fp,
        input logic [2:0] f3
    );
        if (is_fp) begin
            return f3 == F3_W;
        end
        if (is_store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        return ((f3[1:0] == 2'b01) && off[0]) ||
               ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane steering: store replication/strobes and
// load lane extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]              funct3,
    input  logic [1:0]              offset,
    input  logic [DATA_WIDTH-1:0]   store_data,
    input  logic [DATA_WIDTH-1:0]   load_data,
    output logic [DATA_WIDTH-1:0]   store_lanes,
    output logic [DATA_WIDTH/8-1:0] store_strb,
    output logic [DATA_WIDTH-1:0]   load_result
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        store_strb = strobe_pattern(funct3[1:0], offset);

        unique case (funct3[1:0])
            2'b00:   store_lanes = {(DATA_WIDTH/8){store_data[7:0]}};
            2'b01:   store_lanes = {(DATA_WIDTH/16){store_data[15:0]}};
            default: store_lanes = store_data;
        endcase

        shifted = load_data >> {offset, 3'b000};

        unique case (funct3)
            F3_B:    load_result = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   load_result = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_H:    load_result = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   load_result = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with ready/valid memory port and timeout.
// Build option: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 255
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic [31:0]             bus_rs1,
    input  logic [31:0]             bus_rs2,
    input  logic [31:0]             immediate,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [DATA_WIDTH-1:0]   load_unit_output,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    lsu_state_e            state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [2:0]            f3_q, f3_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         wait_q, wait_d;
    logic [DATA_WIDTH-1:0] luo_q, luo_d;

    logic [31:0]             eff_addr;
    logic [ADDR_WIDTH-1:0]   nat_addr;
    logic                    op_legal;
    logic                    op_store;
    logic                    op_fp;
    logic                    misal;
    logic [DATA_WIDTH-1:0]   store_lanes;
    logic [DATA_WIDTH/8-1:0] store_strb;
    logic [DATA_WIDTH-1:0]   load_result;

    lsu_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .funct3      (f3_q),
        .offset      (addr_q[1:0]),
        .store_data  (rs2_q),
        .load_data   (mem_rdata),
        .store_lanes (store_lanes),
        .store_strb  (store_strb),
        .load_result (load_result)
    );

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        f3_d       = f3_q;
        rs2_d      = rs2_q;
        addr_d     = addr_q;
        err_d      = err_q;
        wait_d     = wait_q;
        luo_d      = luo_q;

        eff_addr = bus_rs1 + immediate;
        nat_addr = eff_addr[ADDR_WIDTH-1:0];
        op_store = (opcode == OP_STORE) || (opcode == OP_FSW);
        op_fp    = (opcode == OP_FLW) || (opcode == OP_FSW);
        op_legal = (opcode == OP_LOAD) || (opcode == OP_STORE) ||
                   (opcode == OP_FLW) || (opcode == OP_FSW);

`ifdef LSU_MISALIGN_TRAP_EN
        misal = misaligned(funct3, eff_addr[1:0]);
`else
        // Silently round down to natural alignment instead of trapping.
        misal = 1'b0;
        if (funct3[1:0] == 2'b01) begin
            nat_addr[0] = 1'b0;
        end else if (funct3[1:0] == 2'b10) begin
            nat_addr[1:0] = 2'b00;
        end
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start && op_legal) begin
                    is_store_d = op_store;
                    f3_d       = funct3;
                    rs2_d      = bus_rs2;
                    addr_d     = nat_addr;
                    wait_d     = '0;
                    if (!f3_legal(op_store, op_fp, funct3) || misal) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_ACCESS;
                        err_d   = 1'b0;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    if (!is_store_q) begin
                        luo_d = load_result;
                    end
                end else if ((MAX_WAIT != 0) &&
                             (wait_q == CW'(MAX_WAIT - 1))) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            f3_q       <= '0;
            rs2_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            wait_q     <= '0;
            luo_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            rs2_q      <= rs2_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
            luo_q      <= luo_d;
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign done             = (state_q == S_DONE);
    assign error            = done & err_q;
    assign mem_req          = (state_q == S_ACCESS);
    assign mem_we           = mem_req & is_store_q;
    assign mem_addr         = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign mem_wdata        = store_lanes;
    assign mem_wstrb        = mem_we ? store_strb : '0;
    assign load_unit_output = luo_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances, the second with a
// short timeout so the stuck-memory path is reached quickly.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_a, start_b;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] bus_rs1, bus_rs2, immediate;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        busy_a, done_a, error_a, req_a, we_a;
    logic [31:0] luo_a, addr_a, wdata_a;
    logic [3:0]  wstrb_a;
    logic        busy_b, done_b, error_b, req_b, we_b;
    logic [31:0] luo_b, addr_b, wdata_b;
    logic [3:0]  wstrb_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a),
        .opcode(opcode), .funct3(funct3), .bus_rs1(bus_rs1),
        .bus_rs2(bus_rs2), .immediate(immediate),
        .busy(busy_a), .done(done_a), .error(error_a),
        .load_unit_output(luo_a), .mem_req(req_a), .mem_we(we_a),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wstrb(wstrb_a),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.MAX_WAIT(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b),
        .opcode(opcode), .funct3(funct3), .bus_rs1(bus_rs1),
        .bus_rs2(bus_rs2), .immediate(immediate),
        .busy(busy_b), .done(done_b), .error(error_b),
        .load_unit_output(luo_b), .mem_req(req_b), .mem_we(we_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wstrb(wstrb_b),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit to_b, input logic [6:0] op,
                         input logic [2:0] f3, input logic [31:0] rs1,
                         input logic [31:0] imm, input logic [31:0] rs2);
        opcode    = op;
        funct3    = f3;
        bus_rs1   = rs1;
        immediate = imm;
        bus_rs2   = rs2;
        if (to_b) start_b = 1'b1;
        else      start_a = 1'b1;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        start_a   = 1'b0;
        start_b   = 1'b0;
        opcode    = '0;
        funct3    = '0;
        bus_rs1   = '0;
        bus_rs2   = '0;
        immediate = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_err", 32'(error_a), 32'd0);
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_strb", 32'(wstrb_a), 32'd0);
        chk("rst_addr", addr_a, 32'd0);
        chk("rst_wdata", wdata_a, 32'd0);
        chk("rst_luo", luo_a, 32'd0);
        reset_n = 1'b1;
        tick();

        // SB to 0x103
        issue(0, 7'b0100011, 3'b000, 32'h100, 32'd3, 32'hAB);
        chk("sb_busy", 32'(busy_a), 32'd1);
        chk("sb_req", 32'(req_a), 32'd1);
        chk("sb_we", 32'(we_a), 32'd1);
        chk("sb_addr", addr_a, 32'h100);
        chk("sb_strb", 32'(wstrb_a), 32'b1000);
        chk("sb_wdata", wdata_a, 32'hABABABAB);
        chk("sb_done_n1", 32'(done_a), 32'd0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("sb_done", 32'(done_a), 32'd1);
        chk("sb_err", 32'(error_a), 32'd0);
        chk("sb_req_off", 32'(req_a), 32'd0);
        chk("sb_luo_keep", luo_a, 32'd0);
        tick();
        chk("sb_idle", 32'(busy_a), 32'd0);

        // LB / LBU at 0x102
        issue(0, 7'b0000011, 3'b000, 32'h100, 32'd2, 32'h0);
        chk("lb_addr", addr_a, 32'h100);
        chk("lb_we", 32'(we_a), 32'd0);
        chk("lb_strb", 32'(wstrb_a), 32'd0);
        mem_ready = 1'b1;
        mem_rdata = 32'h00F00000;
        tick();
        mem_ready = 1'b0;
        chk("lb_done", 32'(done_a), 32'd1);
        chk("lb_luo", luo_a, 32'hFFFFFFF0);
        tick();
        issue(0, 7'b0000011, 3'b100, 32'h100, 32'd2, 32'h0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("lbu_luo", luo_a, 32'h000000F0);
        tick();

        // LH at 0x101
        issue(0, 7'b0000011, 3'b001, 32'h100, 32'd1, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lh_mis_req", 32'(req_a), 32'd0);
        chk("lh_mis_done", 32'(done_a), 32'd1);
        chk("lh_mis_err", 32'(error_a), 32'd1);
        chk("lh_mis_luo", luo_a, 32'h000000F0);
`else
        chk("lh_addr", addr_a, 32'h100);
        chk("lh_req", 32'(req_a), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = 32'h12348765;
        tick();
        mem_ready = 1'b0;
        chk("lh_done", 32'(done_a), 32'd1);
        chk("lh_err", 32'(error_a), 32'd0);
        chk("lh_luo", luo_a, 32'hFFFF8765);
`endif
        tick();

        // SH at 0x102, then SW
        issue(0, 7'b0100011, 3'b001, 32'h100, 32'd2, 32'h1234CAFE);
        chk("sh_strb", 32'(wstrb_a), 32'b1100);
        chk("sh_wdata", wdata_a, 32'hCAFECAFE);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        issue(0, 7'b0100111, 3'b010, 32'h200, 32'h10, 32'h89ABCDEF);
        chk("fsw_strb", 32'(wstrb_a), 32'b1111);
        chk("fsw_wdata", wdata_a, 32'h89ABCDEF);
        chk("fsw_addr", addr_a, 32'h210);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();

        // LW with five wait cycles at 0x204
        issue(0, 7'b0000011, 3'b010, 32'h200, 32'd4, 32'h0);
        mem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            chk("lw_wait_req", 32'(req_a), 32'd1);
            chk("lw_wait_addr", addr_a, 32'h204);
            chk("lw_wait_done", 32'(done_a), 32'd0);
            tick();
        end
        chk("lw_req_last", 32'(req_a), 32'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("lw_done", 32'(done_a), 32'd1);
        chk("lw_err", 32'(error_a), 32'd0);
        chk("lw_luo", luo_a, 32'hDEADBEEF);
        tick();

        // Illegal funct3, then a start coincident with done
        issue(0, 7'b0000011, 3'b011, 32'h300, 32'd0, 32'h0);
        chk("ill_req", 32'(req_a), 32'd0);
        chk("ill_done", 32'(done_a), 32'd1);
        chk("ill_err", 32'(error_a), 32'd1);
        chk("ill_luo", luo_a, 32'hDEADBEEF);
        issue(0, 7'b0000011, 3'b010, 32'h300, 32'd0, 32'h0);
        chk("coinc_busy", 32'(busy_a), 32'd0);
        chk("coinc_req", 32'(req_a), 32'd0);

        // Unknown opcode is ignored
        issue(0, 7'b0110011, 3'b010, 32'h300, 32'd0, 32'h0);
        chk("badop_busy", 32'(busy_a), 32'd0);
        chk("badop_done", 32'(done_a), 32'd0);

        // Timeout on the MAX_WAIT=4 instance
        issue(1, 7'b0000011, 3'b010, 32'h300, 32'd0, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h55AA1234;
        tick();
        mem_ready = 1'b0;
        chk("b_lw_luo", luo_b, 32'h55AA1234);
        tick();
        issue(1, 7'b0000011, 3'b010, 32'h304, 32'd0, 32'h0);
        mem_rdata = 32'h0BADF00D;
        for (int i = 0; i < 4; i++) begin
            chk("to_req", 32'(req_b), 32'd1);
            chk("to_done", 32'(done_b), 32'd0);
            tick();
        end
        chk("to_req_drop", 32'(req_b), 32'd0);
        chk("to_done_fin", 32'(done_b), 32'd1);
        chk("to_err", 32'(error_b), 32'd1);
        chk("to_luo", luo_b, 32'h55AA1234);
        tick();

        // Reset mid-access
        issue(0, 7'b0000011, 3'b010, 32'h400, 32'd0, 32'h0);
        chk("rst_mid_req_pre", 32'(req_a), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_req", 32'(req_a), 32'd0);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_post_busy", 32'(busy_a), 32'd0);
        chk("rst_post_done", 32'(done_a), 32'd0);
        issue(0, 7'b0000011, 3'b010, 32'h400, 32'd8, 32'h0);
        chk("post_addr", addr_a, 32'h408);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        chk("post_done", 32'(done_a), 32'd1);
        chk("post_err", 32'(error_a), 32'd0);
        chk("post_luo", luo_a, 32'hCAFEF00D);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
